// File: rtl/spi_port_expander.sv
// SPI mode-0 addressed I/O expander: output/input port registers plus an ID register.
// Define SPI_EXPANDER_AUTOINC_EN to let one transaction stream through consecutive addresses.
module spi_port_expander #(
    parameter int         DATA_W  = 8,
    parameter int         NUM_OUT = 4,
    parameter int         NUM_IN  = 2,
    parameter logic [7:0] ID_VAL  = 8'h5B
) (
    input  logic                                      i_sys_clk,
    input  logic                                      i_rst_n,
    input  logic                                      i_ss,
    input  logic                                      i_sclk,
    input  logic                                      i_mosi,
    output logic                                      o_miso,
    output logic                                      o_miso_oe,
    output logic [NUM_OUT*DATA_W-1:0]                 o_port_out,
    input  logic [((NUM_IN > 0) ? NUM_IN : 1)*DATA_W-1:0] i_port_in,
    output logic                                      o_wr_strobe,
    output logic [6:0]                                o_wr_addr
);

    localparam int              IN_W     = ((NUM_IN > 0) ? NUM_IN : 1) * DATA_W;
    localparam logic [DATA_W-1:0] ID_WORD  = DATA_W'(ID_VAL);
    localparam logic [3:0]      LAST_BIT = 4'(DATA_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

    logic            r_ss_meta, r_ss_sync, r_ss_prev;
    logic            r_sclk_meta, r_sclk_sync, r_sclk_prev;
    logic            r_mosi_meta, r_mosi_sync;
    logic [IN_W-1:0] r_pin_meta, r_pin_sync;

    state_t              r_state;
    logic [3:0]          r_bit_cnt;
    logic                r_cmd_done;
    logic [6:0]          r_cmd_sr;
    logic [6:0]          r_addr;
    logic                r_rnw;
    logic [DATA_W-1:0]   r_data_sr;
    logic [DATA_W-1:0]   r_shift_out;
    logic [DATA_W-1:0]   r_port_out [NUM_OUT];
    logic                r_miso, r_miso_oe, r_wr_strobe;
    logic [6:0]          r_wr_addr;

    logic                w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;
    logic [7:0]          w_cmd_byte;
    logic [DATA_W-1:0]   w_data_word;
    logic [6:0]          w_rd_addr;
    logic [DATA_W-1:0]   w_rd_val;

    // Two-flop synchronisers plus one history flop for edge detection.
    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ss_meta   <= 1'b1;
            r_ss_sync   <= 1'b1;
            r_ss_prev   <= 1'b1;
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
            r_pin_meta  <= '0;
            r_pin_sync  <= '0;
        end else begin
            r_ss_meta   <= i_ss;
            r_ss_sync   <= r_ss_meta;
            r_ss_prev   <= r_ss_sync;
            r_sclk_meta <= i_sclk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_prev <= r_sclk_sync;
            r_mosi_meta <= i_mosi;
            r_mosi_sync <= r_mosi_meta;
            r_pin_meta  <= i_port_in;
            r_pin_sync  <= r_pin_meta;
        end
    end

    assign w_sclk_rise = r_sclk_sync & ~r_sclk_prev;
    assign w_sclk_fall = ~r_sclk_sync & r_sclk_prev;
    assign w_ss_rise   = r_ss_sync & ~r_ss_prev;
    assign w_ss_fall   = ~r_ss_sync & r_ss_prev;
    assign w_cmd_byte  = {r_cmd_sr, r_mosi_sync};
    assign w_data_word = DATA_W'({r_data_sr, r_mosi_sync});

    // Read mux: the command's own address while decoding, the next address in a burst.
    always_comb begin
        w_rd_addr = (r_state == S_CMD) ? w_cmd_byte[6:0] : r_addr + 7'd1;
        w_rd_val  = '0;
        for (int k = 0; k < NUM_OUT; k++)
            if (w_rd_addr == 7'(k)) w_rd_val = r_port_out[k];
        for (int k = 0; k < NUM_IN; k++)
            if (w_rd_addr == 7'(NUM_OUT + k)) w_rd_val = r_pin_sync[k*DATA_W +: DATA_W];
        if (w_rd_addr == 7'h7F) w_rd_val = ID_WORD;
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_cmd_done  <= 1'b0;
            r_cmd_sr    <= '0;
            r_addr      <= '0;
            r_rnw       <= 1'b0;
            r_data_sr   <= '0;
            r_shift_out <= '0;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            for (int k = 0; k < NUM_OUT; k++) r_port_out[k] <= '0;
        end else begin
            r_wr_strobe <= 1'b0;
            r_miso_oe   <= ~r_ss_sync;
            // Deselect outranks everything, including a word completing this cycle.
            if (w_ss_rise) begin
                r_state    <= S_IDLE;
                r_miso     <= 1'b0;
                r_bit_cnt  <= '0;
                r_cmd_done <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_miso <= 1'b0;
                        if (w_ss_fall) begin
                            r_state    <= S_CMD;
                            r_bit_cnt  <= '0;
                            r_cmd_done <= 1'b0;
                        end
                    end
                    S_CMD: begin
                        if (w_sclk_rise && !r_cmd_done) begin
                            r_miso    <= 1'b0;
                            r_cmd_sr  <= w_cmd_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd7) begin
                                r_addr      <= w_cmd_byte[6:0];
                                r_rnw       <= w_cmd_byte[7];
                                r_shift_out <= w_rd_val;
                                r_cmd_done  <= 1'b1;
                                r_bit_cnt   <= '0;
                            end
                        end else if (w_sclk_fall && r_cmd_done) begin
                            r_miso      <= r_shift_out[DATA_W-1];
                            r_shift_out <= r_shift_out << 1;
                            r_state     <= S_DATA;
                        end else begin
                            r_miso <= 1'b0;
                        end
                    end
                    S_DATA: begin
                        if (w_sclk_rise) begin
                            r_data_sr <= w_data_word;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == LAST_BIT) begin
                                r_bit_cnt <= '0;
                                if (!r_rnw && (r_addr < 7'(NUM_OUT))) begin
                                    for (int k = 0; k < NUM_OUT; k++)
                                        if (r_addr == 7'(k)) r_port_out[k] <= w_data_word;
                                    r_wr_strobe <= 1'b1;
                                    r_wr_addr   <= r_addr;
                                end
`ifdef SPI_EXPANDER_AUTOINC_EN
                                r_addr      <= w_rd_addr;
                                r_shift_out <= w_rd_val;
`else
                                r_state     <= S_DONE;
                                r_miso      <= 1'b0;
`endif
                            end
                        end else if (w_sclk_fall) begin
                            r_miso      <= r_shift_out[DATA_W-1];
                            r_shift_out <= r_shift_out << 1;
                        end
                    end
                    default: r_miso <= 1'b0;
                endcase
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_port_out
            assign o_port_out[gi*DATA_W +: DATA_W] = r_port_out[gi];
        end
    endgenerate

    assign o_miso      = r_miso;
    assign o_miso_oe   = r_miso_oe;
    assign o_wr_strobe = r_wr_strobe;
    assign o_wr_addr   = r_wr_addr;

endmodule

// File: tb/tb_spi_port_expander.sv
// Directed and random SPI transactions against a transaction-level model of the expander.
module tb_spi_port_expander;

    localparam int NO = 4;
    localparam int NI = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ss = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        miso, miso_oe, wr_strobe;
    logic [31:0] port_out;
    logic [15:0] port_in = 16'h0000;
    logic [6:0]  wr_addr;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;

    logic [7:0]  model_out [NO];
    logic [6:0]  model_wr_addr;
    logic [7:0]  wq[$];
    logic [15:0] rx;

    spi_port_expander #(.DATA_W(8), .NUM_OUT(NO), .NUM_IN(NI), .ID_VAL(8'h5B)) dut (
        .i_sys_clk  (clk),
        .i_rst_n    (rst_n),
        .i_ss       (ss),
        .i_sclk     (sclk),
        .i_mosi     (mosi),
        .o_miso     (miso),
        .o_miso_oe  (miso_oe),
        .o_port_out (port_out),
        .i_port_in  (port_in),
        .o_wr_strobe(wr_strobe),
        .o_wr_addr  (wr_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (wr_strobe === 1'b1) strobe_cnt++;

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [6:0] a);
        if (a < NO) return model_out[a];
        if (a < NO + NI) return 8'(port_in >> (8 * (int'(a) - NO)));
        if (a == 7'h7F) return 8'h5B;
        return 8'h00;
    endfunction

    function automatic logic [31:0] model_vec();
        logic [31:0] v = '0;
        for (int k = 0; k < NO; k++) v[k*8 +: 8] = model_out[k];
        return v;
    endfunction

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic send_bits(input logic [15:0] val, input int n, output logic [15:0] r);
        r = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = val[i];
            half();
            r = {r[14:0], miso};
            sclk = 1'b1;
            half();
            sclk = 1'b0;
        end
    endtask

    task automatic ss_low();
        ss = 1'b0;
        half();
    endtask

    task automatic ss_high();
        ss = 1'b1;
        half();
        half();
    endtask

    // Full transaction: command then every word in wq, checked against the model.
    task automatic xfer(input string tag, input logic [7:0] cmd);
        logic [7:0] exp_rx[$];
        logic [7:0] got_rx[$];
        logic [6:0] a;
        int         exp_strobes;
        int         s0;
        bit         active;
        a = cmd[6:0];
        exp_strobes = 0;
        active = 1'b1;
        foreach (wq[i]) begin
            if (!active) begin
                exp_rx.push_back(8'h00);
            end else begin
                if (cmd[7]) exp_rx.push_back(model_read(a));
                else if (a < NO) begin
                    model_out[a] = wq[i];
                    model_wr_addr = a;
                    exp_strobes++;
                end
`ifdef SPI_EXPANDER_AUTOINC_EN
                a = a + 7'd1;
`else
                active = 1'b0;
`endif
            end
        end
        s0 = strobe_cnt;
        ss_low();
        check({tag, "_oe"}, {31'd0, miso_oe}, 32'd1);
        send_bits({8'h00, cmd}, 8, rx);
        foreach (wq[i]) begin
            send_bits({8'h00, wq[i]}, 8, rx);
            got_rx.push_back(rx[7:0]);
        end
        ss_high();
        check({tag, "_port_out"}, port_out, model_vec());
        check({tag, "_strobes"}, strobe_cnt - s0, exp_strobes);
        check({tag, "_wr_addr"}, {25'd0, wr_addr}, {25'd0, model_wr_addr});
        if (cmd[7])
            foreach (exp_rx[i]) check({tag, "_rx"}, {24'd0, got_rx[i]}, {24'd0, exp_rx[i]});
        $display("xfer %s cmd=0x%02h words=%0d strobes=%0d", tag, cmd, wq.size(), strobe_cnt - s0);
    endtask

    initial begin
        int s0;
        logic [7:0] cmd;
        int n;
        for (int k = 0; k < NO; k++) model_out[k] = 8'h00;
        model_wr_addr = 7'd0;

        repeat (4) @(negedge clk);
        check("reset_port_out", port_out, 32'd0);
        check("reset_miso", {31'd0, miso}, 32'd0);
        check("reset_oe", {31'd0, miso_oe}, 32'd0);
        check("reset_strobe", {31'd0, wr_strobe}, 32'd0);
        check("reset_wr_addr", {25'd0, wr_addr}, 32'd0);
        rst_n = 1'b1;
        half();

        wq = {8'hA5};
        xfer("write1", 8'h01);
        port_in = 16'h3C96;
        half();
        wq = {8'h00};
        xfer("read_in1", 8'h85);
        xfer("read_id", 8'hFF);
        xfer("read_unmapped", 8'h90);
        wq = {8'hFF};
        xfer("write_unmapped", 8'h10);
        wq = {8'h00};
        xfer("read_out1", 8'h81);

        // Abort part-way through a data word.
        s0 = strobe_cnt;
        ss_low();
        send_bits(16'h0002, 8, rx);
        send_bits(16'h001F, 5, rx);
        ss_high();
        check("abort_port_out", port_out, model_vec());
        check("abort_strobes", strobe_cnt - s0, 0);
        check("abort_oe", {31'd0, miso_oe}, 32'd0);
        $display("xfer abort cmd=0x02 bits=5 strobes=%0d", strobe_cnt - s0);
        wq = {8'h5A};
        xfer("after_abort", 8'h02);

        wq = {8'h11, 8'h22};
        xfer("burst_wrap", 8'h7F);
        wq = {8'h00, 8'h00, 8'h00};
        xfer("burst_read", 8'h80);

        // Reset in the middle of a data word.
        ss_low();
        send_bits(16'h0003, 8, rx);
        send_bits(16'h000F, 4, rx);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_port_out", port_out, 32'd0);
        check("midrst_miso", {31'd0, miso}, 32'd0);
        check("midrst_oe", {31'd0, miso_oe}, 32'd0);
        check("midrst_strobe", {31'd0, wr_strobe}, 32'd0);
        check("midrst_wr_addr", {25'd0, wr_addr}, 32'd0);
        $display("xfer reset_mid_word port_out=0x%08h", port_out);
        for (int k = 0; k < NO; k++) model_out[k] = 8'h00;
        model_wr_addr = 7'd0;
        ss = 1'b1;
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        half();
        wq = {8'hC3};
        xfer("after_reset", 8'h03);

        for (int t = 0; t < 16; t++) begin
            port_in = 16'($urandom);
            half();
            case ($urandom_range(0, 8))
                0, 1, 2, 3: cmd = 8'($urandom_range(0, 3));
                4, 5:       cmd = 8'($urandom_range(4, 5));
                6:          cmd = 8'h7F;
                default:    cmd = {1'b0, 7'($urandom_range(0, 127))};
            endcase
            cmd[7] = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 3);
            wq = {};
            for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
            xfer("random", cmd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
